demux: RTL and testbench



---
 rtl/demux_pkg.sv | 23 ++
 rtl/demux_fallthrough_small_fifo.sv | 51 +++++
 rtl/demux.sv | 146 ++++++++++++++
 tb/tb_demux.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, FSM encoding and log2 helper for the demux
package demux_pkg;

  localparam int MAX_PKT_SIZE = 2048;
  localparam int NUM_OUTPUTS  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  // ceil(log2(value)), never below 1 so pointers always have at least one bit
  function automatic int log2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_fallthrough_small_fifo.sv
// rtl/demux_fallthrough_small_fifo.sv - first-word-fallthrough FIFO with one-free-entry nearly_full
module fallthrough_small_fifo #(
  parameter int WIDTH          = 8,
  parameter int MAX_DEPTH_BITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;

  logic [WIDTH-1:0]          mem [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS:0]   count;
  logic                      do_wr;
  logic                      do_rd;

  assign do_wr       = wr_en && (count != (MAX_DEPTH_BITS+1)'(DEPTH));
  assign do_rd       = rd_en && !empty;
  assign empty       = (count == '0);
  assign nearly_full = (count >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));
  assign dout        = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux.sv
// rtl/demux.sv - 1:4 AXI4-Stream packet demux routed by a tuser index on SOP, invalid indices dropped
module demux
  import demux_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SEL_LSB              = 32,
  parameter int SEL_WIDTH            = 8
) (
  input  logic                              axis_aclk,
  input  logic                              axis_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_0_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_0_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_0_tuser,
  output logic                              m_axis_0_tvalid,
  input  logic                              m_axis_0_tready,
  output logic                              m_axis_0_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_1_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_1_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_1_tuser,
  output logic                              m_axis_1_tvalid,
  input  logic                              m_axis_1_tready,
  output logic                              m_axis_1_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_2_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_2_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_2_tuser,
  output logic                              m_axis_2_tvalid,
  input  logic                              m_axis_2_tready,
  output logic                              m_axis_2_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_3_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_3_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_3_tuser,
  output logic                              m_axis_3_tvalid,
  input  logic                              m_axis_3_tready,
  output logic                              m_axis_3_tlast,
  output logic [31:0]                       drop_count
);

  localparam int KEEP_W     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int FIFO_W     = C_S_AXIS_DATA_WIDTH + C_S_AXIS_TUSER_WIDTH + KEEP_W + 1;
  localparam int DEPTH_BITS = log2(MAX_PKT_SIZE / KEEP_W);
  localparam int DEST_W     = log2(NUM_OUTPUTS);

  state_t                  state;
  logic [DEST_W-1:0]       cur_dest;
  logic [DEST_W-1:0]       dest;
  logic [SEL_WIDTH-1:0]    sel;
  logic                    sel_valid;
  logic                    forward;
  logic                    accept;
  logic [NUM_OUTPUTS-1:0]  nearly_full;
  logic [NUM_OUTPUTS-1:0]  empty;
  logic [NUM_OUTPUTS-1:0]  wr_en;
  logic [NUM_OUTPUTS-1:0]  rd_en;
  logic [NUM_OUTPUTS-1:0]  m_ready;
  logic [FIFO_W-1:0]       fifo_din;
  logic [FIFO_W-1:0]       fifo_dout [NUM_OUTPUTS];

  // NUM_OUTPUTS is a power of two, so "sel < NUM_OUTPUTS" means no bits above DEST_W
  assign sel       = s_axis_tuser[SEL_LSB +: SEL_WIDTH];
  assign sel_valid = ((sel >> DEST_W) == '0);
  assign accept    = s_axis_tvalid && s_axis_tready;
  assign fifo_din  = {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
  assign m_ready   = {m_axis_3_tready, m_axis_2_tready, m_axis_1_tready, m_axis_0_tready};

  always_comb begin
    s_axis_tready = 1'b0;
    forward       = 1'b0;
    dest          = cur_dest;
    case (state)
      IDLE: begin
        if (sel_valid) begin
          dest          = sel[DEST_W-1:0];
          forward       = 1'b1;
          s_axis_tready = !nearly_full[sel[DEST_W-1:0]];
        end else begin
          s_axis_tready = 1'b1;
        end
      end
      FWD: begin
        forward       = 1'b1;
        s_axis_tready = !nearly_full[cur_dest];
      end
      default: s_axis_tready = 1'b1;
    endcase
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state      <= IDLE;
      cur_dest   <= '0;
      drop_count <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!sel_valid && (drop_count != 32'hFFFF_FFFF)) drop_count <= drop_count + 32'd1;
          if (!s_axis_tlast) begin
            state <= sel_valid ? FWD : DROP;
            if (sel_valid) cur_dest <= dest;
          end
        end
        FWD, DROP: begin
          if (s_axis_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
    assign wr_en[i] = accept && forward && (dest == DEST_W'(i));
    assign rd_en[i] = m_ready[i] && !empty[i];

    fallthrough_small_fifo #(
      .WIDTH          (FIFO_W),
      .MAX_DEPTH_BITS (DEPTH_BITS)
    ) u_fifo (
      .clk         (axis_aclk),
      .reset       (axis_reset),
      .din         (fifo_din),
      .wr_en       (wr_en[i]),
      .rd_en       (rd_en[i]),
      .dout        (fifo_dout[i]),
      .nearly_full (nearly_full[i]),
      .empty       (empty[i])
    );
  end

  assign {m_axis_0_tlast, m_axis_0_tuser, m_axis_0_tkeep, m_axis_0_tdata} = fifo_dout[0];
  assign {m_axis_1_tlast, m_axis_1_tuser, m_axis_1_tkeep, m_axis_1_tdata} = fifo_dout[1];
  assign {m_axis_2_tlast, m_axis_2_tuser, m_axis_2_tkeep, m_axis_2_tdata} = fifo_dout[2];
  assign {m_axis_3_tlast, m_axis_3_tuser, m_axis_3_tkeep, m_axis_3_tdata} = fifo_dout[3];
  assign m_axis_0_tvalid = !empty[0];
  assign m_axis_1_tvalid = !empty[1];
  assign m_axis_2_tvalid = !empty[2];
  assign m_axis_3_tvalid = !empty[3];

endmodule

// File: tb/tb_demux.sv
// tb/tb_demux.sv - randomized self-checking bench for demux against a packet-level routing model
module tb_demux;

  localparam int DW    = 256;
  localparam int UW    = 128;
  localparam int KW    = DW / 8;
  localparam int BW    = 1 + UW + KW + DW;
  localparam int DEPTH = 64;

  typedef logic [BW-1:0] beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data;
  logic [KW-1:0] s_keep;
  logic [UW-1:0] s_user;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [DW-1:0] m_data [4];
  logic [KW-1:0] m_keep [4];
  logic [UW-1:0] m_user [4];
  logic [3:0]    m_valid;
  logic [3:0]    m_last;
  logic [3:0]    m_ready;
  logic [31:0]   drop_count;

  int checks = 0;
  int errors = 0;

  // packet-level model: where the current packet goes, what each output should emit
  int          cyc = 0;
  int          occ [4];
  bit          in_pkt = 0;
  int          pkt_dest = -1;
  logic [31:0] drop_exp = '0;
  int          ready_bad = 0;
  bit          accepted;
  bit          rand_ready = 0;
  beat_t       exp_q [4][$];
  beat_t       obs_q [4][$];
  int          acc_cyc [4][$];
  int          obs_cyc [4][$];

  always #5 clk = ~clk;

  demux dut (
    .axis_aclk       (clk),
    .axis_reset      (rst),
    .s_axis_tdata    (s_data),
    .s_axis_tkeep    (s_keep),
    .s_axis_tuser    (s_user),
    .s_axis_tvalid   (s_valid),
    .s_axis_tready   (s_ready),
    .s_axis_tlast    (s_last),
    .m_axis_0_tdata  (m_data[0]),
    .m_axis_0_tkeep  (m_keep[0]),
    .m_axis_0_tuser  (m_user[0]),
    .m_axis_0_tvalid (m_valid[0]),
    .m_axis_0_tready (m_ready[0]),
    .m_axis_0_tlast  (m_last[0]),
    .m_axis_1_tdata  (m_data[1]),
    .m_axis_1_tkeep  (m_keep[1]),
    .m_axis_1_tuser  (m_user[1]),
    .m_axis_1_tvalid (m_valid[1]),
    .m_axis_1_tready (m_ready[1]),
    .m_axis_1_tlast  (m_last[1]),
    .m_axis_2_tdata  (m_data[2]),
    .m_axis_2_tkeep  (m_keep[2]),
    .m_axis_2_tuser  (m_user[2]),
    .m_axis_2_tvalid (m_valid[2]),
    .m_axis_2_tready (m_ready[2]),
    .m_axis_2_tlast  (m_last[2]),
    .m_axis_3_tdata  (m_data[3]),
    .m_axis_3_tkeep  (m_keep[3]),
    .m_axis_3_tuser  (m_user[3]),
    .m_axis_3_tvalid (m_valid[3]),
    .m_axis_3_tready (m_ready[3]),
    .m_axis_3_tlast  (m_last[3]),
    .drop_count      (drop_count)
  );

  function automatic logic [DW-1:0] rand_wide();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int beat_diffs(input int i);
    int n;
    int m;
    n = (obs_q[i].size() > exp_q[i].size()) ? obs_q[i].size() - exp_q[i].size()
                                             : exp_q[i].size() - obs_q[i].size();
    m = (obs_q[i].size() < exp_q[i].size()) ? obs_q[i].size() : exp_q[i].size();
    for (int j = 0; j < m; j++) if (obs_q[i][j] !== exp_q[i][j]) n++;
    return n;
  endfunction

  function automatic int late_beats(input int i, input int lat);
    int n;
    int m;
    n = 0;
    m = (obs_cyc[i].size() < acc_cyc[i].size()) ? obs_cyc[i].size() : acc_cyc[i].size();
    for (int j = 0; j < m; j++) if (obs_cyc[i][j] - acc_cyc[i][j] != lat) n++;
    return n;
  endfunction

  task automatic clear_sb();
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      obs_q[i].delete();
      acc_cyc[i].delete();
      obs_cyc[i].delete();
    end
  endtask

  // one clock: sample handshakes mid-cycle, advance the model, step to the next negedge
  task automatic cycle();
    int sel;
    int dnow;
    bit exp_ready;
    #2;
    if (rst) begin
      clear_sb();
      for (int i = 0; i < 4; i++) occ[i] = 0;
      in_pkt   = 0;
      drop_exp = '0;
    end else begin
      sel       = int'(s_user[32 +: 8]);
      dnow      = in_pkt ? pkt_dest : ((sel < 4) ? sel : -1);
      exp_ready = 1'b1;
      if (dnow >= 0) exp_ready = (occ[dnow] < DEPTH - 1);
      if (s_ready !== exp_ready) ready_bad++;
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i] && m_ready[i]) begin
          obs_q[i].push_back({m_last[i], m_user[i], m_keep[i], m_data[i]});
          obs_cyc[i].push_back(cyc);
          occ[i]--;
        end
      end
      if (s_valid && s_ready) begin
        accepted = 1;
        if (!in_pkt) begin
          pkt_dest = dnow;
          if (dnow < 0 && drop_exp != 32'hFFFF_FFFF) drop_exp++;
        end
        if (pkt_dest >= 0) begin
          exp_q[pkt_dest].push_back({s_last, s_user, s_keep, s_data});
          acc_cyc[pkt_dest].push_back(cyc);
          occ[pkt_dest]++;
        end
        in_pkt = !s_last;
      end
    end
    @(negedge clk);
    cyc++;
    if (rand_ready) m_ready = 4'($urandom);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) cycle();
  endtask

  // sends beats 0..stop-1 of a len-beat packet; non-SOP beats carry random tuser
  task automatic send_pkt(input int sel, input int len, input int stop);
    for (int b = 0; b < stop; b++) begin
      s_data = rand_wide();
      s_keep = $urandom;
      s_user = UW'(rand_wide());
      s_user[32 +: 8] = (b == 0) ? 8'(sel) : 8'($urandom);
      s_last = (b == len - 1);
      s_valid = 1'b1;
      accepted = 0;
      for (int t = 0; t < 400 && !accepted; t++) cycle();
      if (!accepted) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: beat %0d of sel %0d not accepted, waited 400 cycles", b, sel);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0; s_user = '0;
    m_ready = 4'hF;
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    #2;
    checks++; if (m_valid !== 4'b0000) begin errors++; $display("FAIL reset_tvalid: got %b expected 0000", m_valid); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_valid_sel: got %b expected 1", s_ready); end
    s_user[32 +: 8] = 8'd9;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_bad_sel: got %b expected 1", s_ready); end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_three_beat();
    m_ready = 4'hF;
    send_pkt(2, 3, 3);
    idle(4);
    checks++; if (obs_q[2].size() !== 3) begin errors++; $display("FAIL three_beat_count: got %0d expected 3", obs_q[2].size()); end
    checks++; if (beat_diffs(2) !== 0) begin errors++; $display("FAIL three_beat_data: got %0d bad beats expected 0", beat_diffs(2)); end
    checks++; if (late_beats(2, 1) !== 0) begin errors++; $display("FAIL three_beat_latency: got %0d late beats expected 0", late_beats(2, 1)); end
    checks++;
    if (!(obs_q[2].size() == 3 && obs_q[2][2][BW-1] && !obs_q[2][0][BW-1] && !obs_q[2][1][BW-1])) begin
      errors++; $display("FAIL three_beat_tlast: tlast not only on beat 3 (got %0d beats), expected tlast on beat 3", obs_q[2].size());
    end
    checks++;
    if (obs_q[0].size() + obs_q[1].size() + obs_q[3].size() !== 0) begin
      errors++; $display("FAIL three_beat_other_outputs: got %0d beats expected 0", obs_q[0].size() + obs_q[1].size() + obs_q[3].size());
    end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL three_beat_drop_count: got %0d expected 0", drop_count); end
    clear_sb();
  endtask

  task automatic test_back_to_back();
    int sels [5] = '{0, 1, 2, 3, 0};
    int start;
    m_ready = 4'hF;
    start = cyc;
    foreach (sels[k]) send_pkt(sels[k], 1, 1);
    checks++; if (cyc - start !== 5) begin errors++; $display("FAIL b2b_cycles: got %0d cycles for 5 packets expected 5", cyc - start); end
    idle(3);
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_diffs(i) !== 0 || obs_q[i].size() !== ((i == 0) ? 2 : 1)) begin
        errors++; $display("FAIL b2b_out%0d: got %0d beats (%0d bad) expected %0d", i, obs_q[i].size(), beat_diffs(i), (i == 0) ? 2 : 1);
      end
      checks++; if (late_beats(i, 1) !== 0) begin errors++; $display("FAIL b2b_latency%0d: got %0d late beats expected 0", i, late_beats(i, 1)); end
    end
    clear_sb();
  endtask

  task automatic test_drop();
    int start;
    m_ready = 4'hF;
    start = cyc;
    send_pkt(7, 4, 4);
    checks++; if (cyc - start !== 4) begin errors++; $display("FAIL drop_cycles: got %0d cycles for 4 beats expected 4", cyc - start); end
    send_pkt(1, 2, 2);
    idle(4);
    checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL drop_count: got %0d expected 1", drop_count); end
    checks++; if (obs_q[1].size() !== 2 || beat_diffs(1) !== 0) begin
      errors++; $display("FAIL drop_follow_pkt: got %0d beats (%0d bad) expected 2", obs_q[1].size(), beat_diffs(1));
    end
    checks++;
    if (obs_q[0].size() + obs_q[2].size() + obs_q[3].size() !== 0) begin
      errors++; $display("FAIL drop_leak: got %0d beats on other outputs expected 0", obs_q[0].size() + obs_q[2].size() + obs_q[3].size());
    end
    clear_sb();
  endtask

  task automatic test_backpressure();
    m_ready = 4'b0110;
    send_pkt(0, 3, 3);
    fork
      send_pkt(3, 70, 70);
      begin
        repeat (90) @(negedge clk);
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", s_ready); end
        checks++; if (exp_q[3].size() !== DEPTH - 1) begin errors++; $display("FAIL bp_queued: got %0d beats accepted expected %0d", exp_q[3].size(), DEPTH - 1); end
        m_ready[0] = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        checks++; if (obs_q[0].size() !== 3 || beat_diffs(0) !== 0) begin
          errors++; $display("FAIL bp_out0_drain: got %0d beats (%0d bad) expected 3", obs_q[0].size(), beat_diffs(0));
        end
        checks++; if (obs_q[3].size() !== 0) begin errors++; $display("FAIL bp_out3_stalled: got %0d beats expected 0", obs_q[3].size()); end
        m_ready[3] = 1'b1;
      end
    join
    idle(80);
    checks++; if (obs_q[3].size() !== 70 || beat_diffs(3) !== 0) begin
      errors++; $display("FAIL bp_out3_order: got %0d beats (%0d bad) expected 70", obs_q[3].size(), beat_diffs(3));
    end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL bp_ready_pattern: got %0d wrong tready cycles expected 0", ready_bad); end
    clear_sb();
  endtask

  task automatic test_reset_mid();
    m_ready = 4'b1101;
    send_pkt(1, 5, 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #2;
    checks++; if (m_valid !== 4'b0000) begin errors++; $display("FAIL midreset_tvalid: got %b expected 0000", m_valid); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL midreset_drop_count: got %0d expected 0", drop_count); end
    @(negedge clk);
    cyc++;
    m_ready = 4'hF;
    send_pkt(1, 2, 2);
    idle(4);
    checks++; if (obs_q[1].size() !== 2 || beat_diffs(1) !== 0) begin
      errors++; $display("FAIL midreset_new_sop: got %0d beats (%0d bad) expected 2", obs_q[1].size(), beat_diffs(1));
    end
    clear_sb();
  endtask

  task automatic test_saturation();
    m_ready = 4'hF;
    force dut.drop_count = 32'hFFFF_FFFE;
    #1;
    release dut.drop_count;
    drop_exp = 32'hFFFF_FFFE;
    send_pkt($urandom_range(4, 255), 2, 2);
    idle(1);
    checks++; if (drop_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_first: got %h expected ffffffff", drop_count); end
    send_pkt($urandom_range(4, 255), 1, 1);
    send_pkt($urandom_range(4, 255), 3, 3);
    idle(2);
    checks++; if (drop_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffffffff", drop_count); end
    clear_sb();
  endtask

  task automatic test_random();
    int sel;
    rand_ready = 1;
    for (int p = 0; p < 150; p++) begin
      sel = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 255) : $urandom_range(0, 3);
      send_pkt(sel, $urandom_range(1, 6), 6);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_ready = 0;
    m_ready = 4'hF;
    idle(100);
    for (int i = 0; i < 4; i++) begin
      checks++; if (beat_diffs(i) !== 0) begin
        errors++; $display("FAIL random_out%0d: got %0d bad beats of %0d expected 0", i, beat_diffs(i), exp_q[i].size());
      end
    end
    checks++; if (drop_count !== drop_exp) begin errors++; $display("FAIL random_drop_count: got %0d expected %0d", drop_count, drop_exp); end
    checks++; if (ready_bad !== 0) begin errors++; $display("FAIL random_ready: got %0d wrong tready cycles expected 0", ready_bad); end
    clear_sb();
  endtask

  initial begin
    test_reset();
    test_three_beat();
    test_back_to_back();
    test_drop();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
